// File: rtl/spi_register_bank_pkg.sv
// Shared constants, register map and FSM state type for the SPI register bank.
package spi_register_bank_pkg;

  localparam int NUM_REGS   = 9;
  localparam int FRAME_BITS = 16;
  localparam logic [6:0] MAX_ADDR = 7'h7F;

  localparam logic [6:0] ADDR_EN_OUT      = 7'h00;
  localparam logic [6:0] ADDR_EN_PWM_OUT  = 7'h01;
  localparam logic [6:0] ADDR_OUT_3_0     = 7'h02;
  localparam logic [6:0] ADDR_OUT_7_4     = 7'h03;
  localparam logic [6:0] ADDR_G0_CH0_DUTY = 7'h04;
  localparam logic [6:0] ADDR_G0_CH1_DUTY = 7'h05;
  localparam logic [6:0] ADDR_G1_CH0_DUTY = 7'h06;
  localparam logic [6:0] ADDR_G1_CH1_DUTY = 7'h07;
  localparam logic [6:0] ADDR_FREQ_DIV    = 7'h08;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  function automatic logic is_mapped(input logic [6:0] addr);
    return addr < 7'(NUM_REGS);
  endfunction

endpackage

// File: rtl/spi_register_bank_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin plus rise/fall edge pulses.
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_register_bank.sv
// SPI mode-0 target decoding 16-bit frames into reads/writes of nine 8-bit PWM config registers.
module spi_register_bank
  import spi_register_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic       cipo_oe,
  output logic [7:0] reg_en_out,
  output logic [7:0] reg_en_pwm_out,
  output logic [7:0] reg_out_3_0_pwm_gen_channel,
  output logic [7:0] reg_out_7_4_pwm_gen_channel,
  output logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle,
  output logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle,
  output logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle,
  output logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle,
  output logic [7:0] reg_pwm_gen_1_0_frequency_divider,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1) + 1;

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_level), .rise(copi_rise), .fall(copi_fall));
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall));

  logic unused_edges;
  assign unused_edges = ^{sclk_level, copi_rise, copi_fall};

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [15:0]   shift_in;
  logic [7:0]    shift_out;
  logic          read_active;
  logic [7:0]    regs [NUM_REGS];
  logic [SETTLE_W-1:0] settle_cnt;
  logic          settled;
  logic          armed;

  // The ncs synchroniser is preset high, so a host already holding ncs low
  // across reset would look like a fresh falling edge. Frames are only
  // accepted once ncs has been seen high after the chain has settled.
  assign settled = (settle_cnt == SETTLE_W'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (!settled) settle_cnt <= settle_cnt + 1'b1;
      if (settled && ncs_level) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      read_active <= 1'b0;
      cipo        <= 1'b0;
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise) begin
        // End of frame takes priority over any coincident sclk edge.
        if (state == HOLD && shift_in[15] && is_mapped(shift_in[14:8])) begin
          regs[shift_in[11:8]] <= shift_in[7:0];
          wr_strobe            <= 1'b1;
        end
        if (state == SHIFT) frame_err <= 1'b1;
        state       <= IDLE;
        read_active <= 1'b0;
        cipo        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ncs_fall && armed) begin
              state       <= SHIFT;
              bit_cnt     <= '0;
              shift_in    <= '0;
              read_active <= 1'b0;
              cipo        <= 1'b0;
            end
          end
          SHIFT: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[14:0], copi_level};
              bit_cnt  <= bit_cnt + 1'b1;
              // 8th bit: R/W sits in shift_in[6], address completes with copi.
              if (bit_cnt == 5'd7 && !shift_in[6]) begin
                read_active <= 1'b1;
                shift_out   <= is_mapped({shift_in[5:0], copi_level}) ?
                               regs[{shift_in[2:0], copi_level}] : 8'h00;
              end
              if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                state       <= HOLD;
                read_active <= 1'b0;
                cipo        <= 1'b0;
              end
            end else if (sclk_fall && read_active) begin
              cipo      <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cipo_oe = ~ncs_level;

  assign reg_en_out                        = regs[ADDR_EN_OUT[3:0]];
  assign reg_en_pwm_out                    = regs[ADDR_EN_PWM_OUT[3:0]];
  assign reg_out_3_0_pwm_gen_channel       = regs[ADDR_OUT_3_0[3:0]];
  assign reg_out_7_4_pwm_gen_channel       = regs[ADDR_OUT_7_4[3:0]];
  assign reg_pwm_gen_0_ch_0_duty_cycle     = regs[ADDR_G0_CH0_DUTY[3:0]];
  assign reg_pwm_gen_0_ch_1_duty_cycle     = regs[ADDR_G0_CH1_DUTY[3:0]];
  assign reg_pwm_gen_1_ch_0_duty_cycle     = regs[ADDR_G1_CH0_DUTY[3:0]];
  assign reg_pwm_gen_1_ch_1_duty_cycle     = regs[ADDR_G1_CH1_DUTY[3:0]];
  assign reg_pwm_gen_1_0_frequency_divider = regs[ADDR_FREQ_DIV[3:0]];

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank: SPI host tasks, per-scenario checks and a summary.
module tb_spi_register_bank;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo, cipo_oe, wr_strobe, frame_err;
  logic [7:0] obs [9];
  logic [7:0] exp_regs [9];
  logic [7:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int ferr_cnt = 0;

  spi_register_bank dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe),
    .reg_en_out(obs[0]),
    .reg_en_pwm_out(obs[1]),
    .reg_out_3_0_pwm_gen_channel(obs[2]),
    .reg_out_7_4_pwm_gen_channel(obs[3]),
    .reg_pwm_gen_0_ch_0_duty_cycle(obs[4]),
    .reg_pwm_gen_0_ch_1_duty_cycle(obs[5]),
    .reg_pwm_gen_1_ch_0_duty_cycle(obs[6]),
    .reg_pwm_gen_1_ch_1_duty_cycle(obs[7]),
    .reg_pwm_gen_1_0_frequency_divider(obs[8]),
    .wr_strobe(wr_strobe), .frame_err(frame_err));

  // clock / pulse monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clock out `count` bits of `word` starting at index `first`; bits below 0 send 0.
  task automatic spi_bits(input logic [15:0] word, input int first, input int count,
                          output logic [7:0] rd);
    rd = 8'h00;
    for (int k = 0; k < count; k++) begin
      int idx = first - k;
      copi = (idx >= 0) ? word[idx] : 1'b0;
      wait_clks(HALF);
      if (idx >= 0 && idx <= 7) rd[idx] = cipo;
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [7:0] rd);
    ncs = 1'b0;
    wait_clks(HALF);
    spi_bits(word, 15, nbits, rd);
    wait_clks(HALF);
    ncs = 1'b1;
    wait_clks(10);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (obs[i] !== exp_regs[i]) begin
        n_err++;
        $display("FAIL %s reg[%0d]: got %02h want %02h", tag, i, obs[i], exp_regs[i]);
      end
    end
  endtask

  task automatic test_reset();
    wait_clks(4);
    rst = 1'b0;
    wait_clks(6);
    check_regs("reset");
    n_cmp++;
    if ({cipo, cipo_oe, wr_strobe, frame_err} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outs: got %b want 0000", {cipo, cipo_oe, wr_strobe, frame_err});
    end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    ncs = 1'b0;
    wait_clks(HALF);
    n_cmp++;
    if (cipo_oe !== 1'b1) begin
      n_err++; $display("FAIL cipo_oe_active: got %b want 1", cipo_oe);
    end
    spi_bits(16'h8455, 15, 16, rd);
    wait_clks(HALF);
    ncs = 1'b1;
    wait_clks(10);
    exp_regs[4] = 8'h55;
    check_regs("write_8455");
    n_cmp++;
    if (wr_cnt - w0 != 1 || ferr_cnt - f0 != 0) begin
      n_err++; $display("FAIL write_pulses: wr=%0d err=%0d want 1/0", wr_cnt - w0, ferr_cnt - f0);
    end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    int w0;
    spi_frame(16'h88A3, 16, rd);
    exp_regs[8] = 8'hA3;
    w0 = wr_cnt;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h55);
    spi_frame(16'h0800, 16, rd);
    n_cmp++;
    if (rd !== exp_q[0]) begin
      n_err++; $display("FAIL read_08: got %02h want %02h", rd, exp_q[0]);
    end
    void'(exp_q.pop_front());
    spi_frame(16'h0400, 16, rd);
    n_cmp++;
    if (rd !== exp_q[0]) begin
      n_err++; $display("FAIL read_04: got %02h want %02h", rd, exp_q[0]);
    end
    void'(exp_q.pop_front());
    check_regs("after_read");
    n_cmp++;
    if (wr_cnt != w0) begin
      n_err++; $display("FAIL read_no_strobe: got %0d want %0d", wr_cnt, w0);
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] rd;
    int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_frame(16'h8A7F, 16, rd);
    check_regs("unmapped_write");
    n_cmp++;
    if (wr_cnt != w0 || ferr_cnt != f0) begin
      n_err++; $display("FAIL unmapped_pulses: wr=%0d err=%0d want 0/0", wr_cnt - w0, ferr_cnt - f0);
    end
    exp_q.push_back(8'h00);
    spi_frame(16'h0A00, 16, rd);
    n_cmp++;
    if (rd !== exp_q[0]) begin
      n_err++; $display("FAIL read_0a: got %02h want %02h", rd, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_frame(16'h8177, 10, rd);
    check_regs("abort");
    n_cmp++;
    if (ferr_cnt - f0 != 1 || wr_cnt != w0) begin
      n_err++; $display("FAIL abort_pulses: err=%0d wr=%0d want 1/0", ferr_cnt - f0, wr_cnt - w0);
    end
    spi_frame(16'h81FF, 16, rd);
    exp_regs[1] = 8'hFF;
    check_regs("after_abort");
    n_cmp++;
    if (wr_cnt - w0 != 1) begin
      n_err++; $display("FAIL after_abort_strobe: got %0d want 1", wr_cnt - w0);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] rd;
    int w0, f0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_frame(16'h80C3, 20, rd);
    exp_regs[0] = 8'hC3;
    check_regs("overrun");
    n_cmp++;
    if (wr_cnt - w0 != 1 || ferr_cnt != f0) begin
      n_err++; $display("FAIL overrun_pulses: wr=%0d err=%0d want 1/0", wr_cnt - w0, ferr_cnt - f0);
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] rd;
    int w0, f0;
    ncs = 1'b0;
    wait_clks(HALF);
    spi_bits(16'h85AA, 15, 9, rd);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    w0 = wr_cnt; f0 = ferr_cnt;
    spi_bits(16'h85AA, 6, 7, rd);
    wait_clks(HALF);
    ncs = 1'b1;
    wait_clks(10);
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    check_regs("midframe_reset");
    n_cmp++;
    if (wr_cnt != w0 || ferr_cnt != f0) begin
      n_err++; $display("FAIL midframe_pulses: wr=%0d err=%0d want 0/0", wr_cnt - w0, ferr_cnt - f0);
    end
    spi_frame(16'h8312, 16, rd);
    exp_regs[3] = 8'h12;
    check_regs("post_reset_write");
    n_cmp++;
    if (wr_cnt - w0 != 1) begin
      n_err++; $display("FAIL post_reset_strobe: got %0d want 1", wr_cnt - w0);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_unmapped();
    test_abort();
    test_overrun();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
